// File: rtl/md_hilo_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_hilo_sched_pkg
// Description : Shared encodings for the multiply/divide HI/LO scheduler.
//               Holds the md_op instruction encodings and the FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package md_hilo_sched_pkg;

    // md_op encodings as delivered by the E-stage decoder
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    // Scheduler states; done is a registered pulse, not a state
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

endpackage : md_hilo_sched_pkg
`default_nettype wire

// File: rtl/md_calc.sv
`default_nettype none
// ============================================================================
// Module      : md_calc
// Description : Purely combinational multiply/divide result generator.
//               Operates on the latched op and operands.
// Ports       : op      - latched md_op
//               a, b    - latched rs / rt operands
//               hi_res  - result destined for HI (product high / remainder)
//               lo_res  - result destined for LO (product low / quotient)
//               div0    - divide op with a zero divisor (commit suppressed)
// Revision    : 1.0 - initial release
// ============================================================================
module md_calc
    import md_hilo_sched_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;

    // Low 64 bits of a product of sign-extended operands equal the signed
    // product, so both multiplies share an unsigned form.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide through magnitudes: 0x80000000 keeps its bit pattern when
    // negated, so 0x80000000 / -1 yields quotient 0x80000000, remainder 0.
    assign abs_a = a[31] ? (~a + 32'd1) : a;
    assign abs_b = b[31] ? (~b + 32'd1) : b;
    assign q_mag = (abs_b == 32'd0) ? 32'd0 : abs_a / abs_b;
    assign r_mag = (abs_b == 32'd0) ? 32'd0 : abs_a % abs_b;
    assign q_s   = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
    assign r_s   = a[31] ? (~r_mag + 32'd1) : r_mag;   // remainder follows dividend
    assign q_u   = (b == 32'd0) ? 32'd0 : a / b;
    assign r_u   = (b == 32'd0) ? 32'd0 : a % b;

    always_comb begin
        hi_res = 32'd0;
        lo_res = 32'd0;
        case (op)
            MD_MULT:  {hi_res, lo_res} = prod_s;
            MD_MULTU: {hi_res, lo_res} = prod_u;
            MD_DIV:   begin hi_res = r_s; lo_res = q_s; end
            MD_DIVU:  begin hi_res = r_u; lo_res = q_u; end
            default:  begin hi_res = 32'd0; lo_res = 32'd0; end
        endcase
    end

    assign div0 = op[1] & (b == 32'd0);

endmodule : md_calc
`default_nettype wire

// File: rtl/md_hilo_sched.sv
`default_nettype none
// ============================================================================
// Module      : md_hilo_sched
// Description : Multiply/divide controller and HI/LO register file for the
//               5-stage MIPS pipeline. Latches an E-stage mult/div, runs a
//               fixed busy window, commits to HI/LO and stalls D-stage users.
// Ports       : clk, reset (async, active-low)
//               start, md_op, rs_val, rt_val - E-stage md issue
//               mt_we, mt_sel, mt_data       - E-stage mthi/mtlo write
//               d_hilo_use                   - D-stage needs HI/LO
//               stall, busy, done            - pipeline control / status
//               hi, lo                       - HI/LO to the mfhi/mflo mux
// Revision    : 1.0 - initial release
// ============================================================================
module md_hilo_sched
    import md_hilo_sched_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mt_we,
    input  logic        mt_sel,
    input  logic [31:0] mt_data,
    input  logic        d_hilo_use,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] c_mult_load = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] c_div_load  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    md_state_e        state_q;
    md_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    md_op_e           op_q;
    logic [31:0]      rs_q;
    logic [31:0]      rt_q;

    logic             load;
    logic             commit;
    logic             mt_wr;
    logic [31:0]      hi_res;
    logic [31:0]      lo_res;
    logic             div0;

    md_calc u_calc (
        .op     (op_q),
        .a      (rs_q),
        .b      (rt_q),
        .hi_res (hi_res),
        .lo_res (lo_res),
        .div0   (div0)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state and per-edge control. A start in IDLE wins over mt_we; both
    // start and mt_we are ignored while RUN.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        commit  = 1'b0;
        mt_wr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    load    = 1'b1;
                end else if (mt_we) begin
                    mt_wr   = 1'b1;
                end
            end
            S_RUN: begin
                if (cnt_q == c_one) begin
                    state_d = S_IDLE;
                    commit  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            op_q  <= MD_MULT;
            rs_q  <= 32'd0;
            rt_q  <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            done  <= 1'b0;
        end else begin
            done <= commit;
            if (load) begin
                op_q  <= md_op_e'(md_op);
                rs_q  <= rs_val;
                rt_q  <= rt_val;
                cnt_q <= md_op[1] ? c_div_load : c_mult_load;
            end else if (state_q == S_RUN) begin
                cnt_q <= cnt_q - c_one;
            end
            // A zero divisor still runs the full window but leaves HI/LO intact
            if (commit && !div0) begin
                hi <= hi_res;
                lo <= lo_res;
            end
            if (mt_wr) begin
                if (mt_sel) hi <= mt_data;
                else        lo <= mt_data;
            end
        end
    end

    assign busy  = (state_q == S_RUN);
    // Combinational so a D-stage HI/LO user is held on the very issue cycle
    assign stall = d_hilo_use & (busy | start);

endmodule : md_hilo_sched
`default_nettype wire

// File: tb/tb_md_hilo_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_hilo_sched
// Description : Directed self-checking bench for md_hilo_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_hilo_sched;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mt_we;
    logic        mt_sel;
    logic [31:0] mt_data;
    logic        d_hilo_use;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    md_hilo_sched #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .md_op      (md_op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .mt_we      (mt_we),
        .mt_sel     (mt_sel),
        .mt_data    (mt_data),
        .d_hilo_use (d_hilo_use),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // inj: 0 none, 1 mt write alongside start, 2 mthi during the busy window
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int ncyc, input logic [31:0] ehi,
                          input logic [31:0] elo, input int inj);
        int n;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        if (inj == 1) begin
            mt_we   = 1'b1;
            mt_sel  = 1'b0;
            mt_data = 32'h5555_5555;
        end
        tick();
        start  = 1'b0;
        mt_we  = 1'b0;
        rs_val = 32'h0BAD_0BAD;
        rt_val = 32'h0BAD_0BAD;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            n++;
            if (inj == 2 && n == 2) begin
                mt_we   = 1'b1;
                mt_sel  = 1'b1;
                mt_data = 32'hDEAD_BEEF;
            end else begin
                mt_we = 1'b0;
            end
            tick();
        end
        mt_we = 1'b0;
        check({name, "_busy_cycles"}, n, ncyc);
        check({name, "_done"}, {31'd0, done}, 32'd1);
        check({name, "_hi"}, hi, ehi);
        check({name, "_lo"}, lo, elo);
        tick();
        check({name, "_done_cleared"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int dcnt;
        reset      = 1'b0;
        start      = 1'b0;
        md_op      = 2'b00;
        rs_val     = 32'd0;
        rt_val     = 32'd0;
        mt_we      = 1'b0;
        mt_sel     = 1'b0;
        mt_data    = 32'd0;
        d_hilo_use = 1'b0;

        // Reset then idle
        tick();
        tick();
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        reset = 1'b1;
        tick();

        // Multiply / divide results
        run_op("mult",  2'b00, 32'hFFFF_FFFE, 32'd3, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA, 0);
        run_op("div",   2'b10, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("divu",  2'b11, 32'd7,         32'd2, 10, 32'd1,         32'd3,         0);

        // Stall window for multu 5x7 with mflo in D
        d_hilo_use = 1'b1;
        md_op      = 2'b01;
        rs_val     = 32'd5;
        rt_val     = 32'd7;
        start      = 1'b1;
        #1;
        check("stall_issue", {31'd0, stall}, 32'd1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_busy", {31'd0, stall}, 32'd1);
            tick();
        end
        check("stall_release", {31'd0, stall}, 32'd0);
        check("stall_busy_low", {31'd0, busy}, 32'd0);
        check("stall_lo", lo, 32'd35);
        check("stall_hi", hi, 32'd0);
        d_hilo_use = 1'b0;
        tick();

        // mtlo in IDLE
        mt_we   = 1'b1;
        mt_sel  = 1'b0;
        mt_data = 32'h0000_1234;
        tick();
        mt_we = 1'b0;
        check("mtlo_lo", lo, 32'h0000_1234);
        check("mtlo_hi", hi, 32'd0);

        // Divide by zero, plain / with mthi mid-run / with mt write alongside start
        run_op("div0",       2'b10, 32'd5, 32'd0, 10, 32'd0, 32'h0000_1234, 0);
        run_op("div0_mthi",  2'b11, 32'd9, 32'd0, 10, 32'd0, 32'h0000_1234, 2);
        run_op("div0_mtst",  2'b10, 32'd9, 32'd0, 10, 32'd0, 32'h0000_1234, 1);

        // Overflow and negative divisor
        run_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 0);
        run_op("div_negb",   2'b10, 32'd7,         32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD, 0);

        // Reset in the middle of a mult
        md_op  = 2'b00;
        rs_val = 32'd6;
        rt_val = 32'd7;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_busy_async", {31'd0, busy}, 32'd0);
        check("mid_hi", hi, 32'd0);
        check("mid_lo", lo, 32'd0);
        tick();
        reset = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) dcnt++;
        end
        check("mid_no_done", dcnt, 32'd0);
        check("mid_busy_after", {31'd0, busy}, 32'd0);
        check("mid_lo_after", lo, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_md_hilo_sched
`default_nettype wire
